// File: rtl/vls_sequencer.sv
// Vector load/store sequencer: walks up to MAX_VLEN elements between memory and the VRF.
// Optional macro VLS_STRIDE_EN selects a latched byte stride; otherwise the step is DATA_W/8.
module vls_sequencer #(
  parameter int MAX_VLEN = 8,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              VLS_Enable,
  input  logic              Load_Store,
  input  logic [31:0]       VLR,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [2:0]        vreg_idx,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              vrf_we,
  output logic              vrf_re,
  output logic [2:0]        vrf_reg,
  output logic [2:0]        vrf_elem,
  output logic [DATA_W-1:0] vrf_wdata,
  input  logic [DATA_W-1:0] vrf_rdata,
  output logic              VLS_done,
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_VLEN + 1);

  typedef enum logic [2:0] {
    IDLE, MREQ, WB, VRD, VLAT, MWR, DONE
  } state_t;

  state_t              state;
  logic [2:0]          vreg_q;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    elem;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   rd_buf;
  logic [DATA_W-1:0]   wr_buf;
  logic [ADDR_W-1:0]   step;
  logic [CNT_W-1:0]    vlr_clamped;
  logic                last_elem;

`ifdef VLS_STRIDE_EN
  logic [ADDR_W-1:0]   stride_q;
  assign step = stride_q;
`else
  logic unused_stride;
  assign unused_stride = ^stride;
  assign step = ADDR_W'(DATA_W / 8);
`endif

  assign vlr_clamped = (VLR > 32'(MAX_VLEN)) ? CNT_W'(MAX_VLEN) : VLR[CNT_W-1:0];
  // count is never 0 outside IDLE/DONE, so count-1 cannot underflow where it matters.
  assign last_elem   = (elem == count - CNT_W'(1));

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      vreg_q <= '0;
      count  <= '0;
      elem   <= '0;
      addr   <= '0;
      rd_buf <= '0;
      wr_buf <= '0;
`ifdef VLS_STRIDE_EN
      stride_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (VLS_Enable) begin
          vreg_q <= vreg_idx;
          addr   <= base_addr;
          count  <= vlr_clamped;
          elem   <= '0;
`ifdef VLS_STRIDE_EN
          stride_q <= stride;
`endif
          if (vlr_clamped == '0) state <= DONE;
          else                   state <= Load_Store ? MREQ : VRD;
        end
        MREQ: if (mem_ack) begin
          rd_buf <= mem_rdata;
          state  <= WB;
        end
        WB: begin
          if (last_elem) state <= DONE;
          else begin
            elem  <= elem + CNT_W'(1);
            addr  <= addr + step;
            state <= MREQ;
          end
        end
        VRD:  state <= VLAT;
        VLAT: begin
          wr_buf <= vrf_rdata;
          state  <= MWR;
        end
        MWR: if (mem_ack) begin
          if (last_elem) state <= DONE;
          else begin
            elem  <= elem + CNT_W'(1);
            addr  <= addr + step;
            state <= VRD;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode: every output depends only on registered state and datapath.
  assign mem_rd    = (state == MREQ);
  assign mem_wr    = (state == MWR);
  assign mem_addr  = addr;
  assign mem_wdata = wr_buf;
  assign vrf_we    = (state == WB);
  assign vrf_re    = (state == VRD);
  assign vrf_reg   = vreg_q;
  assign vrf_elem  = 3'(elem);
  assign vrf_wdata = rd_buf;
  assign VLS_done  = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_vls_sequencer.sv
// Directed bench for vls_sequencer with a behavioural memory responder and VRF read model.
module tb_vls_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        VLS_Enable;
  logic        Load_Store;
  logic [31:0] VLR;
  logic [31:0] base_addr;
  logic [2:0]  vreg_idx;
  logic [31:0] stride;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        vrf_we;
  logic        vrf_re;
  logic [2:0]  vrf_reg;
  logic [2:0]  vrf_elem;
  logic [31:0] vrf_wdata;
  logic [31:0] vrf_rdata;
  logic        VLS_done;
  logic        busy;

  localparam logic [31:0] MEM_KEY = 32'h5A5A_0000;

  int checks = 0;
  int errors = 0;

  bit ack_tied  = 1'b1;
  int ack_delay = 0;

  logic [31:0] rd_addr_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [2:0]  we_reg_q[$];
  logic [2:0]  we_elem_q[$];
  logic [31:0] we_data_q[$];
  int rd_cycles, wr_cycles, both_cnt, done_cnt;

  vls_sequencer dut (
    .clk(clk), .rst_n(rst_n), .VLS_Enable(VLS_Enable), .Load_Store(Load_Store),
    .VLR(VLR), .base_addr(base_addr), .vreg_idx(vreg_idx), .stride(stride),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .vrf_we(vrf_we), .vrf_re(vrf_re),
    .vrf_reg(vrf_reg), .vrf_elem(vrf_elem), .vrf_wdata(vrf_wdata),
    .vrf_rdata(vrf_rdata), .VLS_done(VLS_done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] vrf_val(input logic [2:0] r, input logic [2:0] e);
    return {16'hC0DE, 5'd0, r, 5'd0, e};
  endfunction

  // Memory responder: either ack held high, or ack after ack_delay wait cycles.
  always @(negedge clk) begin : responder
    int wcnt;
    mem_rdata = mem_addr ^ MEM_KEY;
    if (ack_tied) mem_ack = 1'b1;
    else if (mem_rd || mem_wr) begin
      mem_ack = (wcnt == ack_delay);
      wcnt    = (wcnt == ack_delay) ? 0 : wcnt + 1;
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
  end

  always @(posedge clk) if (vrf_re) vrf_rdata <= vrf_val(vrf_reg, vrf_elem);

  // Transaction log, sampled mid-cycle after the responder has settled.
  always @(negedge clk) begin
    #2;
    if (mem_rd && mem_wr) both_cnt++;
    if (mem_rd) rd_cycles++;
    if (mem_wr) wr_cycles++;
    if (mem_ack && mem_rd) rd_addr_q.push_back(mem_addr);
    if (mem_ack && mem_wr) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
    if (vrf_we) begin
      we_reg_q.push_back(vrf_reg);
      we_elem_q.push_back(vrf_elem);
      we_data_q.push_back(vrf_wdata);
    end
    if (VLS_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    we_reg_q.delete(); we_elem_q.delete(); we_data_q.delete();
    rd_cycles = 0; wr_cycles = 0; done_cnt = 0;
  endtask

  // Drives a request on a falling edge; the next rising edge is the enable edge.
  task automatic start(input logic ld, input logic [31:0] vlr, input logic [31:0] base,
                       input logic [2:0] vreg, input logic [31:0] strd);
    @(negedge clk);
    Load_Store = ld; VLR = vlr; base_addr = base; vreg_idx = vreg; stride = strd;
    VLS_Enable = 1'b1;
    @(posedge clk);
    #1 VLS_Enable = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (VLS_done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; VLS_Enable = 1'b0; Load_Store = 1'b0; VLR = '0;
    base_addr = '0; vreg_idx = '0; stride = '0;
    both_cnt = 0;
    clear_log();
    repeat (2) @(negedge clk);
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_done",     64'(VLS_done), 64'd0);
    check("rst_rd_wr",    64'({mem_rd, mem_wr, vrf_we, vrf_re}), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_vrf",      64'({vrf_reg, vrf_elem}), 64'd0);
    rst_n = 1'b1;

    // Load of 3 with ack tied high: done lands in the 7th cycle after the enable edge.
    clear_log();
    start(1'b1, 32'd3, 32'h100, 3'd2, 32'd0);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      check($sformatf("load3_done_cyc%0d", i), 64'(VLS_done), 64'(i == 7));
    end
    @(negedge clk);
    check("load3_idle", 64'(busy), 64'd0);
    check("load3_nrd", 64'(rd_addr_q.size()), 64'd3);
    check("load3_nwe", 64'(we_data_q.size()), 64'd3);
    if (rd_addr_q.size() == 3 && we_data_q.size() == 3)
      for (int i = 0; i < 3; i++) begin
        check($sformatf("load3_addr%0d", i), 64'(rd_addr_q[i]), 64'(32'h100 + 4 * i));
        check($sformatf("load3_elem%0d", i), 64'({we_reg_q[i], we_elem_q[i]}), 64'({3'd2, 3'(i)}));
        check($sformatf("load3_data%0d", i), 64'(we_data_q[i]), 64'((32'h100 + 4 * i) ^ MEM_KEY));
      end

    // Store of 2 from reg 5 with three wait cycles per request.
    clear_log();
    ack_tied = 1'b0; ack_delay = 3;
    start(1'b0, 32'd2, 32'h200, 3'd5, 32'd0);
    wait_done("store2");
    check("store2_nwr", 64'(wr_addr_q.size()), 64'd2);
    check("store2_wr_held_cycles", 64'(wr_cycles), 64'd8);
    check("store2_no_rd", 64'(rd_cycles), 64'd0);
    if (wr_addr_q.size() == 2)
      for (int i = 0; i < 2; i++) begin
        check($sformatf("store2_addr%0d", i), 64'(wr_addr_q[i]), 64'(32'h200 + 4 * i));
        check($sformatf("store2_data%0d", i), 64'(wr_data_q[i]), 64'(vrf_val(3'd5, 3'(i))));
      end
    check("store2_one_done", 64'(done_cnt), 64'd1);

    // VLR = 0: straight to DONE, no accesses.
    clear_log();
    ack_tied = 1'b1;
    start(1'b1, 32'd0, 32'h500, 3'd1, 32'd0);
    @(negedge clk);
    check("vlr0_done", 64'({VLS_done, busy}), 64'b11);
    @(negedge clk);
    check("vlr0_idle", 64'({VLS_done, busy}), 64'b00);
    check("vlr0_no_access", 64'(rd_cycles + wr_cycles), 64'd0);
    check("vlr0_no_vrf", 64'(we_data_q.size()), 64'd0);

    // VLR = 20 clamps to MAX_VLEN = 8.
    clear_log();
    start(1'b1, 32'd20, 32'h600, 3'd4, 32'd0);
    wait_done("vlr20");
    check("vlr20_nrd", 64'(rd_addr_q.size()), 64'd8);
    check("vlr20_nwe", 64'(we_elem_q.size()), 64'd8);
    if (rd_addr_q.size() == 8 && we_elem_q.size() == 8) begin
      check("vlr20_last_addr", 64'(rd_addr_q[7]), 64'h61C);
      check("vlr20_last_elem", 64'(we_elem_q[7]), 64'd7);
    end

    // Reset during the second MREQ of a 4-element load.
    clear_log();
    ack_tied = 1'b0; ack_delay = 2;
    start(1'b1, 32'd4, 32'h700, 3'd6, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (mem_rd && mem_addr == 32'h704) found = 1'b1;
    end
    check("rst_mid_reached_mreq2", 64'(found), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_async_ctrl", 64'({mem_rd, mem_wr, vrf_we, vrf_re, VLS_done, busy}), 64'd0);
    check("rst_mid_async_addr", 64'(mem_addr), 64'd0);
    repeat (3) @(negedge clk);
    check("rst_mid_no_done", 64'(done_cnt), 64'd0);
    rst_n = 1'b1;
    clear_log();
    ack_tied = 1'b1;
    start(1'b1, 32'd1, 32'h300, 3'd3, 32'd0);
    wait_done("rst_restart");
    check("rst_restart_nrd", 64'(rd_addr_q.size()), 64'd1);
    if (rd_addr_q.size() == 1 && we_elem_q.size() == 1) begin
      check("rst_restart_addr", 64'(rd_addr_q[0]), 64'h300);
      check("rst_restart_elem", 64'(we_elem_q[0]), 64'd0);
    end

    // Address wrap-around, with or without the stride feature.
    clear_log();
    start(1'b1, 32'd2, 32'hFFFF_FFF0, 3'd0, 32'h10);
    wait_done("wrap");
    check("wrap_nrd", 64'(rd_addr_q.size()), 64'd2);
    if (rd_addr_q.size() == 2) begin
      check("wrap_addr0", 64'(rd_addr_q[0]), 64'hFFFF_FFF0);
`ifdef VLS_STRIDE_EN
      check("wrap_addr1", 64'(rd_addr_q[1]), 64'h0000_0000);
`else
      check("wrap_addr1", 64'(rd_addr_q[1]), 64'hFFFF_FFF4);
`endif
    end

    // A second enable while busy, with different inputs, must be ignored.
    clear_log();
    start(1'b1, 32'd3, 32'h400, 3'd7, 32'd0);
    @(negedge clk);
    VLR = 32'd5; base_addr = 32'h800; Load_Store = 1'b0; VLS_Enable = 1'b1;
    @(posedge clk);
    #1 VLS_Enable = 1'b0;
    wait_done("busy_en");
    repeat (5) @(negedge clk);
    check("busy_en_nrd", 64'(rd_addr_q.size()), 64'd3);
    check("busy_en_nwr", 64'(wr_cycles), 64'd0);
    check("busy_en_one_done", 64'(done_cnt), 64'd1);
    check("busy_en_idle", 64'(busy), 64'd0);
    if (rd_addr_q.size() == 3) check("busy_en_last_addr", 64'(rd_addr_q[2]), 64'h408);

    check("rd_wr_exclusive", 64'(both_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vls_sequencer.md
VLS_SEQUENCER -- requirements
Module: vls_sequencer

Interface
REQ-001 Parameter: MAX_VLEN, default 8, maximum element count per vector instruction.
REQ-002 Parameter: DATA_W, default 32, element width in bits.
REQ-003 Parameter: ADDR_W, default 32, memory address width in bits.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: VLS_Enable  input  1  start request from Control_Unit; sampled only in IDLE.
REQ-007 Port: Load_Store  input  1  1 = vector load (memory to VRF), 0 = vector store (VRF to memory).
REQ-008 Port: VLR  input  32  requested element count.
REQ-009 Port: base_addr  input  ADDR_W  address of element 0.
REQ-010 Port: vreg_idx  input  3  target or source vector register.
REQ-011 Port: stride  input  ADDR_W  byte stride; used only when VLS_STRIDE_EN is defined.
REQ-012 Port: mem_addr / mem_rd / mem_wr / mem_wdata  output  ADDR_W/1/1/DATA_W  memory request.
REQ-013 Port: mem_rdata  input  DATA_W  read data, valid in the mem_ack cycle.
REQ-014 Port: mem_ack  input  1  memory completion.
REQ-015 Port: vrf_we / vrf_re / vrf_reg / vrf_elem / vrf_wdata  output  1/1/3/3/DATA_W  VRF port.
REQ-016 Port: vrf_rdata  input  DATA_W  VRF read data, valid one cycle after vrf_re.
REQ-017 Port: VLS_done / busy  output  1/1  completion pulse / operation in progress.

Function
REQ-018 States: IDLE, MREQ, WB, VRD, VLAT, MWR, DONE; all outputs decode from registered state and datapath registers (Moore).
REQ-019 In IDLE with VLS_Enable=1: latch Load_Store, vreg_idx, base_addr, stride; count = min(VLR, MAX_VLEN); elem = 0; go to MREQ (load) or VRD (store).
REQ-020 If the clamped count is 0: go to DONE directly, with no memory or VRF access.
REQ-021 MREQ: mem_rd=1, mem_addr=addr; hold until mem_ack=1; on the ack cycle capture mem_rdata and go to WB.
REQ-022 WB: vrf_we=1, vrf_reg=latched index, vrf_elem=elem, vrf_wdata=captured data, for exactly one cycle.
REQ-023 VRD: vrf_re=1, vrf_elem=elem, for one cycle. VLAT: latch vrf_rdata into the write buffer. MWR: mem_wr=1, mem_wdata=buffer, mem_addr=addr; hold until mem_ack.
REQ-024 After WB (load) or an acked MWR (store): if elem == count-1, go to DONE; else elem+1, addr advances by the step, and the FSM returns to MREQ or VRD.
REQ-025 Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
REQ-026 DONE: VLS_done=1 for exactly one cycle, then IDLE.
REQ-027 busy=1 in every state except IDLE.
REQ-028 VLS_Enable while busy is ignored; input changes after latching have no effect.
REQ-029 mem_rd and mem_wr are never both 1; mem_ack outside MREQ/MWR is ignored.

Reset
REQ-030 rst_n=0 forces IDLE immediately, including mid-operation; no completion pulse is issued.
REQ-031 Reset values: all outputs 0, elem=0, count=0, addr=0, buffers=0.

Configuration
REQ-032 Macro VLS_STRIDE_EN defined: address step = latched stride (may be 0 or any value, modulo arithmetic applies).
REQ-033 Macro VLS_STRIDE_EN undefined: address step = DATA_W/8 (4 bytes by default); the stride port is ignored.

Verification
REQ-034 Load, VLR=3, base=0x100, mem_ack tied 1: reads 0x100/0x104/0x108; VRF elems 0..2 written; VLS_done in the 7th cycle after the enable edge.
REQ-035 Store, VLR=2, vreg_idx=5, ack delayed 3 cycles per request: mem_wr is held through the wait; mem_wdata equals VRF reg 5 elems 0 and 1; exactly 2 writes occur.
REQ-036 VLR=0, then VLR=20: the first gives VLS_done one cycle after IDLE with no mem_rd/mem_wr; the second performs exactly 8 accesses.
REQ-037 rst_n low during the second MREQ of a VLR=4 load: outputs go to 0 asynchronously; no VLS_done; a new load after release starts at elem 0.
REQ-038 VLS_STRIDE_EN defined, stride=0x10, base=0xFFFFFFF0, VLR=2: addresses 0xFFFFFFF0 then 0x00000000; undefined: 0xFFFFFFF0 then 0xFFFFFFF4.
REQ-039 VLS_Enable pulsed while busy with a different VLR: ignored; the original count completes with a single VLS_done.
